// File: rtl/filter_load_ctrl_pkg.sv
// Shared definitions for the filter weight loader.
//   TAPS     : weights per 3x3 filter (fixed at 9)
//   ST_*     : sequencer state encodings
package filter_load_ctrl_pkg;

  localparam int TAPS = 9;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_READY = 2'd3;

endpackage

// File: rtl/filter_load_ctrl_addr_gen.sv
// Weight-memory address generator for the filter loader.
// Holds the latched base address, the filter index and the tap counter,
// and forms mem_addr = base + filter_idx*TAPS + tap (mod 2^ADDR_W).
// Ports:
//   clk, rst      : clock, async active-high reset
//   load          : job accepted; latch base_addr, clear counters
//   base_addr     : address of weight 0 of filter 0
//   tap_en        : a read is issued this cycle; advance tap counter
//   next_filter   : advance to the next filter
//   mem_addr      : current read address
//   last_tap      : tap counter is on the final tap
//   filter_idx    : current filter index
module filter_load_ctrl_addr_gen
  import filter_load_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              tap_en,
  input  logic              next_filter,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              last_tap,
  output logic [CNT_W-1:0]  filter_idx
);

  // Wide enough that base + idx*9 + tap never overflows before truncation.
  localparam int SUM_W = ADDR_W + CNT_W + 4;

  logic [ADDR_W-1:0] base_q;
  logic [3:0]        tap_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q     <= '0;
      tap_q      <= '0;
      filter_idx <= '0;
    end else if (load) begin
      base_q     <= base_addr;
      tap_q      <= '0;
      filter_idx <= '0;
    end else begin
      if (tap_en)
        tap_q <= last_tap ? 4'd0 : tap_q + 4'd1;
      if (next_filter)
        filter_idx <= filter_idx + CNT_W'(1);
    end
  end

  assign last_tap = (tap_q == 4'(TAPS - 1));

  assign mem_addr = ADDR_W'(SUM_W'(base_q)
                          + SUM_W'(filter_idx) * SUM_W'(TAPS)
                          + SUM_W'(tap_q));

endmodule

// File: rtl/filter_load_ctrl.sv
// Sequencer that loads 3x3 filters, one at a time, from weight memory into
// a single-entry filter_buffer and hands each to the convolver.
// Ports:
//   clk, rst         : clock, async active-high reset
//   start            : 1-cycle job request (honoured only when idle)
//   base_addr        : address of weight 0 of filter 0 (latched on start)
//   num_filters      : filters in the job (latched on start)
//   mem_rd_en        : weight read strobe
//   mem_addr         : weight read address
//   mem_rd_data      : read data, one cycle after mem_rd_en
//   shifting, inp    : shift enable / weight into filter_buffer
//   filter_valid     : all taps of the current filter are loaded
//   filter_idx       : filter currently loaded or loading
//   filter_consumed  : convolver done with current filter
//   busy             : job in progress
//   done             : 1-cycle pulse at job end
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing the 9 weight reads of the current filter
// DRAIN | last read returning, last shift in flight
// READY | filter loaded and held until consumed
module filter_load_ctrl
  import filter_load_ctrl_pkg::*;
#(
  parameter int WID_FILTER = 16,
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_filters,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [WID_FILTER-1:0] mem_rd_data,
  output logic                  shifting,
  output logic [WID_FILTER-1:0] inp,
  output logic                  filter_valid,
  output logic [CNT_W-1:0]      filter_idx,
  input  logic                  filter_consumed,
  output logic                  busy,
  output logic                  done
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  num_q;
  logic              shifting_q;
  logic              done_q;
  logic              accept;
  logic              last_tap;
  logic              last_filter;
  logic              next_filter;
  logic [ADDR_W-1:0] gen_addr;

  assign accept      = (state == ST_IDLE) && start && (num_filters != '0);
  assign last_filter = ((CNT_W+1)'(filter_idx) + (CNT_W+1)'(1)) >= (CNT_W+1)'(num_q);
  assign next_filter = (state == ST_READY) && filter_consumed && !last_filter;

  filter_load_ctrl_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (accept),
    .base_addr   (base_addr),
    .tap_en      (mem_rd_en),
    .next_filter (next_filter),
    .mem_addr    (gen_addr),
    .last_tap    (last_tap),
    .filter_idx  (filter_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      num_q      <= '0;
      shifting_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shifting_q <= mem_rd_en;
      done_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_filters != '0) begin
              num_q <= num_filters;
              state <= ST_FETCH;
            end else begin
              // Empty job: acknowledge immediately without touching memory.
              done_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (last_tap)
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state <= ST_READY;
        end
        ST_READY: begin
          if (filter_consumed) begin
            if (last_filter) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd_en    = (state == ST_FETCH);
  assign mem_addr     = mem_rd_en ? gen_addr : '0;
  assign shifting     = shifting_q;
  // Read data lines up with the delayed strobe; held at 0 otherwise.
  assign inp          = shifting_q ? mem_rd_data : '0;
  assign filter_valid = (state == ST_READY);
  assign busy         = (state != ST_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_filter_load_ctrl.sv
module tb_filter_load_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = '0;
  logic [7:0]  num_filters = '0;
  logic [15:0] mem_rd_data = '0;
  logic        filter_consumed = 1'b0;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic        shifting;
  logic [15:0] inp;
  logic        filter_valid;
  logic [7:0]  filter_idx;
  logic        busy;
  logic        done;

  int n_chk = 0;
  int n_pass = 0;
  int shift_cnt = 0;
  logic [15:0] fbuf [1:9];

  always #5 clk = ~clk;

  filter_load_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .num_filters     (num_filters),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rd_data     (mem_rd_data),
    .shifting        (shifting),
    .inp             (inp),
    .filter_valid    (filter_valid),
    .filter_idx      (filter_idx),
    .filter_consumed (filter_consumed),
    .busy            (busy),
    .done            (done)
  );

  // Weight memory: each word holds its own address; one-cycle read latency.
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= {4'h0, mem_addr};

  // filter_buffer stand-in: out1 takes the newest weight, out9 the oldest.
  always @(posedge clk) begin
    if (shifting) begin
      for (int i = 9; i > 1; i--) fbuf[i] <= fbuf[i-1];
      fbuf[1]   <= inp;
      shift_cnt <= shift_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int waddr(input int base, input int f, input int k);
    return (base + 9 * f + k) % 4096;
  endfunction

  // Runs one job starting at cycle 0 (caller is #1 after a rising edge).
  // Filter f is fetched from cycle fs[f]; it is consumed at cycle cs[f],
  // chosen randomly a few cycles after it becomes valid.
  task automatic run_job(input logic [11:0] base, input int num, input bit stray);
    int fs[$];
    int cs[$];
    int t0;
    int d;
    int done_t;
    int sc0;
    t0 = 1;
    for (int f = 0; f < num; f++) begin
      d = $urandom_range(0, 3);
      fs.push_back(t0);
      cs.push_back(t0 + 10 + d);
      t0 = t0 + 11 + d;
    end
    done_t = (num == 0) ? 1 : cs[num-1] + 1;
    sc0 = shift_cnt;
    for (int t = 0; t <= done_t + 2; t++) begin
      int  f;
      int  k;
      bit  exp_rd, exp_sh, exp_val, exp_busy;
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      f = -1;
      for (int i = 0; i < num; i++)
        if (t >= fs[i] && t <= cs[i]) f = i;
      k        = (f >= 0) ? t - fs[f] : -1;
      exp_rd   = (f >= 0) && (k <= 8);
      exp_sh   = (f >= 0) && (k >= 1) && (k <= 9);
      exp_val  = (f >= 0) && (k >= 10);
      exp_busy = (num > 0) && (t >= 1) && (t < done_t);
      chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
      chk("shifting", 32'(shifting), 32'(exp_sh));
      chk("filter_valid", 32'(filter_valid), 32'(exp_val));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(t == done_t));
      if (exp_rd) chk("mem_addr", 32'(mem_addr), 32'(waddr(int'(base), f, k)));
      if (exp_sh) chk("inp", 32'(inp), 32'(waddr(int'(base), f, k - 1)));
      if (f >= 0) chk("filter_idx", 32'(filter_idx), 32'(f));
      if (f >= 0 && k == 10) begin
        chk("out9", 32'(fbuf[9]), 32'(waddr(int'(base), f, 0)));
        chk("out1", 32'(fbuf[1]), 32'(waddr(int'(base), f, 8)));
      end
      start = 1'b0;
      filter_consumed = 1'b0;
      if (t == 0) begin
        start       = 1'b1;
        base_addr   = base;
        num_filters = 8'(num);
      end else if (stray && exp_busy && ($urandom_range(0, 3) == 0)) begin
        start       = 1'b1;
        base_addr   = 12'($urandom);
        num_filters = 8'($urandom);
      end
      if (f >= 0 && t == cs[f]) filter_consumed = 1'b1;
      else if (stray && f >= 0 && !exp_val && ($urandom_range(0, 2) == 0)) filter_consumed = 1'b1;
    end
    start = 1'b0;
    filter_consumed = 1'b0;
    chk("shift_count", 32'(shift_cnt - sc0), 32'(9 * num));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_shifting", 32'(shifting), 32'd0);
    chk("rst_valid", 32'(filter_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(filter_idx), 32'd0);
    rst = 1'b0;

    run_job(12'h010, 1, 1'b0);
    run_job(12'h100, 2, 1'b0);
    run_job(12'h000, 0, 1'b0);
    run_job(12'h040, 1, 1'b1);
    run_job(12'hFFC, 1, 1'b0);

    // Abort mid-fetch with an asynchronous reset.
    start = 1'b1; base_addr = 12'h3A0; num_filters = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    chk("arst_mem_addr", 32'(mem_addr), 32'd0);
    chk("arst_shifting", 32'(shifting), 32'd0);
    chk("arst_inp", 32'(inp), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(filter_valid), 32'd0);
    chk("arst_idx", 32'(filter_idx), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_job(12'h200, 2, 1'b0);

    for (int j = 0; j < 30; j++)
      run_job(12'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
